// File: rtl/ram64m_pkg.sv
// Shared definitions for RAM64M-based sequencers: primitive geometry,
// address/occupancy types and the wrapping pointer helper.
package ram64m_pkg;

  localparam int RAM64M_DEPTH         = 64;
  localparam int RAM64M_AW            = 6;
  localparam int RAM64M_BITS_PER_PRIM = 3;

  typedef logic [RAM64M_AW-1:0] ram64m_addr_t;
  typedef logic [RAM64M_AW:0]   ram64m_occ_t;

  // Advance a RAM pointer; the 6-bit width makes 63 -> 0 wrap implicit.
  function automatic ram64m_addr_t ram64m_ptr_inc(input ram64m_addr_t ptr);
    return ptr + 6'd1;
  endfunction

endpackage

// File: rtl/ram64m_fifo_outreg.sv
// Output register stage for RAM64M sequencers: captures the asynchronous
// RAM read data into a valid/ready holding register (first-word-fall-through).
// Reports 'load' so the owner can advance its read pointer and occupancy.
module ram64m_fifo_outreg #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              avail,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              load,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data
);

  logic              out_vld_r;
  logic [DATA_W-1:0] out_data_r;
  logic              load_s;

  // Refill whenever the RAM holds a word and the register is empty or draining.
  always_comb begin
    load_s = avail & (~out_vld_r | m_ready);
  end

  // Holding register: load from RAM, or drop valid when consumed without refill.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_vld_r  <= 1'b0;
      out_data_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      out_vld_r  <= 1'b1;
      out_data_r <= rdata;
    end else if (out_vld_r & m_ready) begin
      out_vld_r  <= 1'b0;
    end else begin
      out_vld_r  <= out_vld_r;
    end
  end

  // Drive outputs straight from the registers.
  always_comb begin
    load    = load_s;
    m_valid = out_vld_r;
    m_data  = out_data_r;
  end

endmodule

// File: rtl/ram64m_fifo_ctrl.sv
// Sequencing controller for a 64-entry FIFO built on external RAM64M
// primitives (3 data bits per primitive on ports A/B/C). Owns the write port
// and the shared read address; total capacity is 64 RAM words plus one word
// in the output register. Full/empty is resolved by the occupancy counter only.
// Optional build macro RAM64M_FIFO_LEVEL_EN adds LEVEL (total words held) and
// a sticky OVF flag for push attempts while full.
module ram64m_fifo_ctrl
  import ram64m_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int AFULL_THR = 56
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic [DATA_W-1:0]    S_DATA,
  input  logic                 S_VALID,
  output logic                 S_READY,
  output logic [DATA_W-1:0]    M_DATA,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic                 RAM_WE,
  output logic [RAM64M_AW-1:0] RAM_WADDR,
  output logic [DATA_W-1:0]    RAM_WDATA,
  output logic [RAM64M_AW-1:0] RAM_RADDR,
  input  logic [DATA_W-1:0]    RAM_RDATA,
  output logic                 AFULL
`ifdef RAM64M_FIFO_LEVEL_EN
  ,
  output logic [RAM64M_AW:0]   LEVEL,
  output logic                 OVF
`endif
);

  ram64m_addr_t wr_ptr_r;
  ram64m_addr_t rd_ptr_r;
  ram64m_occ_t  cnt_r;
  logic         clr_s;
  logic         s_ready_s;
  logic         push_s;
  logic         avail_s;
  logic         load_s;
  logic         m_valid_s;

  // Flush has exactly the same effect as reset.
  always_comb begin
    clr_s = RST | FLUSH;
  end

  // Push qualification from registered occupancy only (no path from M_READY).
  always_comb begin
    s_ready_s = (cnt_r != ram64m_occ_t'(RAM64M_DEPTH));
    push_s    = S_VALID & s_ready_s;
    avail_s   = (cnt_r != {(RAM64M_AW+1){1'b0}});
  end

  // RAM port and flag outputs.
  always_comb begin
    RAM_WE    = push_s;
    RAM_WADDR = wr_ptr_r;
    RAM_WDATA = S_DATA;
    RAM_RADDR = rd_ptr_r;
    S_READY   = s_ready_s;
    AFULL     = (cnt_r >= ram64m_occ_t'(AFULL_THR));
    M_VALID   = m_valid_s;
  end

  // Write/read pointers, each advancing on its own transfer.
  always_ff @(posedge CLK) begin
    if (clr_s) begin
      wr_ptr_r <= {RAM64M_AW{1'b0}};
      rd_ptr_r <= {RAM64M_AW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ram64m_ptr_inc(wr_ptr_r);
      end
      if (load_s) begin
        rd_ptr_r <= ram64m_ptr_inc(rd_ptr_r);
      end
    end
  end

  // RAM occupancy: push adds, load removes, both together cancel.
  always_ff @(posedge CLK) begin
    if (clr_s) begin
      cnt_r <= {(RAM64M_AW+1){1'b0}};
    end else begin
      case ({push_s, load_s})
        2'b10:   cnt_r <= cnt_r + 7'd1;
        2'b01:   cnt_r <= cnt_r - 7'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  ram64m_fifo_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk     (CLK),
    .clr     (clr_s),
    .avail   (avail_s),
    .m_ready (M_READY),
    .rdata   (RAM_RDATA),
    .load    (load_s),
    .m_valid (m_valid_s),
    .m_data  (M_DATA)
  );

`ifdef RAM64M_FIFO_LEVEL_EN
  logic ovf_r;

  // Sticky overflow: any push attempt while full, cleared only by reset/flush.
  always_ff @(posedge CLK) begin
    if (clr_s) begin
      ovf_r <= 1'b0;
    end else if (S_VALID & ~s_ready_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Total words held: RAM occupancy plus the output register.
  always_comb begin
    LEVEL = cnt_r + {{RAM64M_AW{1'b0}}, m_valid_s};
    OVF   = ovf_r;
  end
`endif

endmodule
